rv32_fetch_unit: RTL and testbench

Parametrised instruction-fetch stage replacing the free-running `pc + 4` counter in front of the decoder. It owns the program counter, issues word-aligned requests on a valid/ready instruction-memory port, and buffers in-order responses in a DEPTH-entry queue. The queue presents instructions with their PC to decode over a valid/ready handshake. A redirect input (branch/jump/trap) reloads the PC, flushes buffered instructions and discards responses still in flight.

---
 rtl/rv32_fetch_unit.sv | 77 +++++++
 tb/tb_rv32_fetch_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32_fetch_unit.sv
// rv32_fetch_unit: owns the PC, issues credit-limited word-aligned imem requests and
// buffers in-order responses in a DEPTH-entry queue; redirect reloads PC and flushes.
module rv32_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW+1:0] DEPTH_W = DEPTH[AW+1:0];

    logic [31:0] pc;
    logic [31:0] q_pc [DEPTH];
    logic [31:0] q_data [DEPTH];
    logic [AW:0] rd_ptr, fill_ptr, alloc_ptr;
    logic [AW:0] inflight, drop, filled;
    logic [AW+1:0] used;
    logic pop, acc, keep;

    // Unfilled slots are exactly the non-dropped in-flight requests, so credit is
    // in-flight requests plus filled slots; a same-cycle pop returns its slot early.
    assign filled = fill_ptr - rd_ptr;
    assign pop = instr_valid && instr_ready;
    assign used = {1'b0, inflight} + {1'b0, filled} - {{(AW+1){1'b0}}, pop};
    assign imem_req_valid = (used < DEPTH_W) && !redirect_valid;
    assign imem_req_addr = pc;
    assign acc = imem_req_valid && imem_req_ready;
    assign keep = imem_rsp_valid && (drop == '0);
    assign instr_valid = rd_ptr != fill_ptr;
    assign instr = q_data[rd_ptr[AW-1:0]];
    assign instr_pc = q_pc[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc <= RESET_PC;
            rd_ptr <= '0;
            fill_ptr <= '0;
            alloc_ptr <= '0;
            inflight <= '0;
            drop <= '0;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[31:2], 2'b00};
            rd_ptr <= '0;
            fill_ptr <= '0;
            alloc_ptr <= '0;
            inflight <= inflight - {{AW{1'b0}}, imem_rsp_valid};
            drop <= inflight - {{AW{1'b0}}, imem_rsp_valid};
        end else begin
            if (acc) begin
                pc <= pc + 32'd4;
                alloc_ptr <= alloc_ptr + ONE;
            end
            if (pop) rd_ptr <= rd_ptr + ONE;
            if (keep) fill_ptr <= fill_ptr + ONE;
            if (imem_rsp_valid && drop != '0) drop <= drop - ONE;
            inflight <= inflight + {{AW{1'b0}}, acc} - {{AW{1'b0}}, imem_rsp_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (acc) q_pc[alloc_ptr[AW-1:0]] <= pc;
        if (keep) q_data[fill_ptr[AW-1:0]] <= imem_rsp_data;
    end
endmodule

// File: tb/tb_rv32_fetch_unit.sv
// tb_rv32_fetch_unit: directed and randomized checks of rv32_fetch_unit against a
// queue-based model of outstanding requests and visible instructions.
module tb_rv32_fetch_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    rv32_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    req_t        pend[$];
    logic [31:0] vis[$];
    logic [31:0] dut_pops[$];
    logic [31:0] exp_req_pc;
    int          cyc, checks, errors, nacc;
    logic        s_iv, s_rv;
    logic [31:0] s_ipc, s_raddr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] pop_at(input int i);
        return (i < dut_pops.size()) ? dut_pops[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive inputs just after the edge, compare at the falling edge, advance model.
    task automatic step(input bit rv, input logic [31:0] rpc, input bit rr, input bit ir, input int lat);
        bit exp_iv, exp_rv, pop;
        req_t r;
        logic [31:0] tmp;
        redirect_valid = rv;
        redirect_pc = rpc;
        imem_req_ready = rr;
        instr_ready = ir;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        if (pend.size() > 0) begin
            if (pend[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data = mem_word(pend[0].addr);
            end
        end
        @(negedge clk);
        s_iv = instr_valid;
        s_rv = imem_req_valid;
        s_ipc = instr_pc;
        s_raddr = imem_req_addr;
        exp_iv = vis.size() > 0;
        pop = exp_iv && ir;
        exp_rv = !rv && (pend.size() + vis.size() - int'(pop) < DEPTH);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, exp_iv});
        if (exp_iv) begin
            chk("instr_pc", instr_pc, vis[0]);
            chk("instr", instr, mem_word(vis[0]));
        end
        chk("imem_req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        if (exp_rv) chk("imem_req_addr", imem_req_addr, exp_req_pc);
        if (instr_valid === 1'b1 && ir) dut_pops.push_back(instr_pc);
        if (imem_rsp_valid) r = pend.pop_front();
        if (rv) begin
            vis.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            exp_req_pc = {rpc[31:2], 2'b00};
        end else begin
            if (pop) tmp = vis.pop_front();
            if (imem_rsp_valid && !r.stale) vis.push_back(r.addr);
            if (exp_rv && rr) begin
                pend.push_back('{addr: exp_req_pc, due: cyc + lat, stale: 1'b0});
                exp_req_pc = exp_req_pc + 32'd4;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        resetn = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        instr_ready = 1'b0;
        #2;
        chk("reset instr_valid", {31'b0, instr_valid}, 32'd0);
        pend.delete();
        vis.delete();
        dut_pops.delete();
        exp_req_pc = 32'h0;
        cyc = 0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        exp_req_pc = 32'h0;

        // streaming after reset release, 1-cycle memory
        do_reset();
        step(0, 0, 1, 1, 1);
        chk("p1 first req_valid", {31'b0, s_rv}, 32'd1);
        chk("p1 first req_addr", s_raddr, 32'h0);
        step(0, 0, 1, 1, 1);
        chk("p1 c1 instr_valid", {31'b0, s_iv}, 32'd0);
        step(0, 0, 1, 1, 1);
        chk("p1 c2 instr_valid", {31'b0, s_iv}, 32'd1);
        chk("p1 c2 instr_pc", s_ipc, 32'h0);
        step(0, 0, 1, 1, 1);
        chk("p1 c3 instr_pc", s_ipc, 32'h4);
        step(0, 0, 1, 1, 1);
        chk("p1 c4 instr_pc", s_ipc, 32'h8);

        // decode stalled: credit limits to DEPTH requests
        do_reset();
        nacc = 0;
        repeat (6) begin
            step(0, 0, 1, 0, 1);
            nacc += int'(s_rv);
        end
        chk("p2 accepted", nacc, 32'd2);
        chk("p2 stalled req_valid", {31'b0, s_rv}, 32'd0);
        repeat (6) step(0, 0, 1, 1, 1);
        chk("p2 drain 0", pop_at(0), 32'h0);
        chk("p2 drain 1", pop_at(1), 32'h4);
        chk("p2 resume", pop_at(2), 32'h8);

        // redirect with two requests in flight
        do_reset();
        step(0, 0, 1, 1, 3);
        step(0, 0, 1, 1, 3);
        dut_pops.delete();
        step(1, 32'h100, 1, 1, 3);
        chk("p3 redirect req_valid", {31'b0, s_rv}, 32'd0);
        step(0, 0, 1, 1, 1);
        chk("p3 redirect addr", s_raddr, 32'h100);
        repeat (10) step(0, 0, 1, 1, 1);
        chk("p3 first new", pop_at(0), 32'h100);
        chk("p3 second new", pop_at(1), 32'h104);
        step(1, 32'h203, 1, 1, 1);
        step(0, 0, 0, 1, 1);
        chk("p3 aligned addr", s_raddr, 32'h200);

        // redirect colliding with pop and response, then idle credit
        do_reset();
        repeat (5) step(0, 0, 1, 1, 1);
        step(1, 32'h400, 1, 1, 1);
        chk("p4 overlap pop", {31'b0, s_iv}, 32'd1);
        dut_pops.delete();
        repeat (8) step(0, 0, 1, 1, 1);
        chk("p4 first new", pop_at(0), 32'h400);
        repeat (8) step(0, 0, 0, 1, 1);
        chk("p4 idle req_valid", {31'b0, s_rv}, 32'd1);
        chk("p4 idle instr_valid", {31'b0, s_iv}, 32'd0);

        // randomized traffic
        do_reset();
        repeat (10000)
            step($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, int'($urandom_range(1, 5)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
